// File: rtl/ysyx_exu_csr_ctrl_pkg.sv
// Shared definitions for the EXU CSR sequencer: op codes, FSM states,
// CSR addresses, mstatus bit positions and trap cause codes.
package ysyx_exu_csr_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_CSRRW  = 3'd0,
    OP_CSRRS  = 3'd1,
    OP_CSRRC  = 3'd2,
    OP_ECALL  = 3'd3,
    OP_EBREAK = 3'd4,
    OP_MRET   = 3'd5
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_REDIR = 2'd3
  } csr_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  localparam int CAUSE_ECALL_M    = 11;
  localparam int CAUSE_BREAKPOINT = 3;

  // Ops that read and possibly write a CSR named by the instruction.
  function automatic logic op_is_csr(input csr_op_e op);
    return (op == OP_CSRRW) || (op == OP_CSRRS) || (op == OP_CSRRC);
  endfunction

  // Ops that enter a trap and redirect fetch to mtvec.
  function automatic logic op_is_trap(input csr_op_e op);
    return (op == OP_ECALL) || (op == OP_EBREAK);
  endfunction

  // Ops the controller understands at all; 6 and 7 are illegal.
  function automatic logic op_is_legal(input csr_op_e op);
    return op_is_csr(op) || op_is_trap(op) || (op == OP_MRET);
  endfunction

endpackage

// File: rtl/ysyx_csr_wdata_gen.sv
// Combinational new-value generator for CSR read-modify-write and the
// MRET mstatus update. Also flags ops that must not write at all.
module ysyx_csr_wdata_gen
  import ysyx_exu_csr_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  csr_op_e         i_op,
  input  logic [XLEN-1:0] i_old,
  input  logic [XLEN-1:0] i_wdata,
  output logic [XLEN-1:0] o_new,
  output logic            o_suppress
);

  logic w_wdata_zero;
  assign w_wdata_zero = (i_wdata == '0);

  // Select the new CSR value and whether the write is suppressed.
  always_comb begin
    o_new      = '0;
    o_suppress = 1'b1;
    case (i_op)
      OP_CSRRW: begin
        o_new      = i_wdata;
        o_suppress = 1'b0;
      end
      OP_CSRRS: begin
        o_new      = i_old | i_wdata;
        o_suppress = w_wdata_zero;
      end
      OP_CSRRC: begin
        o_new      = i_old & ~i_wdata;
        o_suppress = w_wdata_zero;
      end
      OP_MRET: begin
        o_new               = i_old;
        o_new[MSTATUS_MIE]  = i_old[MSTATUS_MPIE];
        o_new[MSTATUS_MPIE] = 1'b1;
        o_suppress          = 1'b0;
      end
      default: begin
        o_new      = '0;
        o_suppress = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_exu_csr_ctrl.sv
// EXU CSR sequencer: one system request at a time, IDLE -> READ -> WRITE
// (-> REDIR for traps and MRET). Drives the CSR file's two write ports and
// returns either the old CSR value or a fetch redirect.
module ysyx_exu_csr_ctrl
  import ysyx_exu_csr_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int R_W  = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [R_W-1:0]  req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [XLEN-1:0] req_pc,
  input  logic            flush,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_illegal,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic [R_W-1:0]  csr_waddr0,
  output logic [R_W-1:0]  csr_waddr1,
  output logic [XLEN-1:0] csr_wdata0,
  output logic [XLEN-1:0] csr_wdata1,
  output logic            csr_wen,
  output logic            csr_exu_valid,
  output logic            csr_ecallen,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc
);

  localparam logic [R_W-1:0] A_MSTATUS = R_W'(CSR_MSTATUS);
  localparam logic [R_W-1:0] A_MEPC    = R_W'(CSR_MEPC);
  localparam logic [R_W-1:0] A_MCAUSE  = R_W'(CSR_MCAUSE);

  csr_state_e      r_state;
  csr_state_e      w_next;
  csr_op_e         r_op;
  logic [R_W-1:0]  r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_old;

  logic            w_accept;
  logic            w_is_csr;
  logic            w_is_trap;
  logic            w_is_mret;
  logic            w_read_only;
  logic            w_write_try;
  logic [XLEN-1:0] w_new;
  logic            w_suppress;

  assign w_accept    = (r_state == ST_IDLE) && req_valid && !flush;
  assign w_is_csr    = op_is_csr(r_op);
  assign w_is_trap   = op_is_trap(r_op);
  assign w_is_mret   = (r_op == OP_MRET);
  assign w_read_only = (r_addr[R_W-1 -: 2] == 2'b11);
  // A CSR op "tries" to write unless it is RS/RC with a zero mask.
  assign w_write_try = w_is_csr && !w_suppress;

  ysyx_csr_wdata_gen #(
    .XLEN (XLEN)
  ) u_wdata_gen (
    .i_op       (r_op),
    .i_old      (r_old),
    .i_wdata    (r_wdata),
    .o_new      (w_new),
    .o_suppress (w_suppress)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request latch on acceptance, old-value capture during READ.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op    <= OP_CSRRW;
      r_addr  <= '0;
      r_wdata <= '0;
      r_pc    <= '0;
      r_old   <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= csr_op_e'(req_op);
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_pc    <= req_pc;
      end
      if (r_state == ST_READ) begin
        r_old <= csr_rdata;
      end
    end
  end

  // Next state and all outputs, decoded from the current state.
  always_comb begin
    w_next         = r_state;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_illegal    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    csr_waddr0     = '0;
    csr_waddr1     = '0;
    csr_wdata0     = '0;
    csr_wdata1     = '0;
    csr_wen        = 1'b0;
    csr_exu_valid  = 1'b0;
    csr_ecallen    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          w_next = ST_READ;
        end
      end
      ST_READ: begin
        // Port-0 address doubles as the read address.
        if (w_is_csr) begin
          csr_waddr0 = r_addr;
        end else if (w_is_trap || w_is_mret) begin
          csr_waddr0 = A_MSTATUS;
        end
        w_next = flush ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        if (w_is_csr) begin
          csr_waddr0 = r_addr;
          csr_waddr1 = r_addr;
          csr_wdata0 = w_new;
          csr_wdata1 = w_new;
          rsp_valid  = 1'b1;
          rsp_rdata  = r_old;
          if (w_write_try && w_read_only) begin
            rsp_illegal = 1'b1;
          end else if (w_write_try) begin
            csr_wen       = 1'b1;
            csr_exu_valid = 1'b1;
          end
          w_next = ST_IDLE;
        end else if (w_is_trap) begin
          csr_waddr0    = A_MCAUSE;
          csr_wdata0    = (r_op == OP_ECALL) ? XLEN'(CAUSE_ECALL_M)
                                             : XLEN'(CAUSE_BREAKPOINT);
          csr_waddr1    = A_MEPC;
          csr_wdata1    = r_pc;
          csr_wen       = 1'b1;
          csr_exu_valid = 1'b1;
          csr_ecallen   = 1'b1;
          w_next        = ST_REDIR;
        end else if (w_is_mret) begin
          csr_waddr0    = A_MSTATUS;
          csr_waddr1    = A_MSTATUS;
          csr_wdata0    = w_new;
          csr_wdata1    = w_new;
          csr_wen       = 1'b1;
          csr_exu_valid = 1'b1;
          w_next        = ST_REDIR;
        end else begin
          rsp_valid   = 1'b1;
          rsp_illegal = 1'b1;
          w_next      = ST_IDLE;
        end
      end
      ST_REDIR: begin
        // mtvec/mepc are sampled after the WRITE-cycle commit landed.
        redirect_valid = 1'b1;
        redirect_pc    = w_is_trap ? csr_mtvec : csr_mepc;
        w_next         = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/ysyx_exu_csr_ctrl.md
Name: ysyx_exu_csr_ctrl

Overview:
Sequencer in front of the EXU CSR register file (two write ports, read port addressed by write-port-0 address).
- Accepts one system request at a time from the EXU: CSRRW/CSRRS/CSRRC, ECALL, EBREAK or MRET.
- Performs the read-modify-write or trap-entry/return write sequence over several cycles.
- Returns the old CSR value to the EXU, or a PC redirect to the fetch path.

Parameters:
XLEN, `YSYX_W_WIDTH, datapath width
R_W, 12, CSR address width

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  EXU request valid
req_ready  out  1  controller can accept a request (IDLE only)
req_op  in  3  op code: 0 CSRRW, 1 CSRRS, 2 CSRRC, 3 ECALL, 4 EBREAK, 5 MRET; 6-7 illegal
req_addr  in  R_W  CSR address (CSR ops)
req_wdata  in  XLEN  rs1 value or zero-extended uimm
req_pc  in  XLEN  PC of the requesting instruction
flush  in  1  pipeline flush
rsp_valid  out  1  one-cycle pulse: CSR op complete
rsp_rdata  out  XLEN  old CSR value, for rd
rsp_illegal  out  1  qualifies rsp_valid: write to read-only CSR, or illegal op
redirect_valid  out  1  one-cycle pulse: redirect fetch
redirect_pc  out  XLEN  target PC
csr_waddr0  out  R_W  CSR port-0 address (also read address)
csr_waddr1  out  R_W  CSR port-1 address
csr_wdata0  out  XLEN  port-0 write data
csr_wdata1  out  XLEN  port-1 write data
csr_wen  out  1  CSR write enable
csr_exu_valid  out  1  CSR commit qualifier
csr_ecallen  out  1  trap-entry mstatus update (MPIE<=MIE, MIE<=0)
csr_rdata  in  XLEN  CSR read data for csr_waddr0
csr_mtvec  in  XLEN  current mtvec
csr_mepc  in  XLEN  current mepc

Behaviour:
Reset (rst low, any state): state IDLE; every output 0 except req_ready=1. Internal latches cleared.

IDLE:
- req_ready=1.
- On req_valid: latch op/addr/wdata/pc, go to READ.
- flush in IDLE blocks acceptance that cycle.

READ:
- csr_waddr0 = latched addr for CSR ops; MSTATUS (0x300) for ECALL/EBREAK/MRET.
- Capture csr_rdata into old.
- flush high: go to IDLE with no write and no response.
- Otherwise go to WRITE.

WRITE (flush ignored from here on):
- CSRRW: new = wdata.
- CSRRS: new = old | wdata.
- CSRRC: new = old & ~wdata.
- Read-only address (addr[11:10]==2'b11):
  - Write attempted (CSRRW, or RS/RC with wdata!=0): csr_wen=0, rsp_illegal=1.
  - Otherwise: read is legal, csr_wen=0.
- CSRRS/CSRRC with wdata==0: csr_wen=0, no side effect.
- Other CSR ops: csr_wen=1, csr_exu_valid=1, waddr0=waddr1=addr, wdata0=wdata1=new.
- CSR ops complete this cycle: rsp_valid=1, rsp_rdata=old, next state IDLE.
- ECALL/EBREAK:
  - waddr0=MCAUSE (0x342), wdata0 = 11 (ECALL) or 3 (EBREAK).
  - waddr1=MEPC (0x341), wdata1 = pc.
  - csr_wen=1, csr_exu_valid=1, csr_ecallen=1.
  - Next state REDIR.
- MRET:
  - waddr0=waddr1=MSTATUS.
  - wdata = old with MIE<=old.MPIE, MPIE<=1.
  - csr_wen=1, csr_exu_valid=1.
  - Next state REDIR.
- Illegal op (6-7): no write; rsp_valid=1, rsp_illegal=1, rsp_rdata=0; next state IDLE.

REDIR:
- redirect_valid=1 for one cycle.
- redirect_pc = csr_mtvec (trap) or csr_mepc (MRET), sampled in this cycle after the WRITE commit.
- Next state IDLE.

Latency, request accepted at edge T:
- CSR-op response asserted in cycle T+2.
- Redirect asserted in cycle T+3.
- Throughput: one request per 3 cycles (CSR op) or 4 cycles (trap/MRET).

Other rules:
- Outside WRITE: csr_wen, csr_exu_valid and csr_ecallen are 0.
- Outside REDIR: redirect_valid is 0.
- The controller never writes the same CSR from both ports with different data.

Decomposition:
- Shared header ysyx_csr.svh gains: op encodings, state enum (IDLE/READ/WRITE/REDIR), cause codes (11, 3), read-only address test. MSTATUS bit indices already live there.
- One combinational sub-module, ysyx_csr_wdata_gen: takes op, old, wdata; returns new value and the write-suppress flag. It covers RW/RS/RC and the MRET mstatus update.

Test Plan:
1. CSRRW 0x305, wdata 0x80000100, old 0 -> T+2: wen=1, waddr0=0x305, wdata0=0x80000100, rsp_rdata=0; req_ready low T+1..T+2.
2. CSRRS 0x300, wdata 0x8, mstatus 0x1800 -> write 0x1808, rsp_rdata=0x1800. Repeat with wdata 0 -> wen=0, rsp_valid=1.
3. ECALL, pc 0x80000040, mtvec 0x80000100 -> WRITE: mcause<=11, mepc<=0x80000040, ecallen=1; T+3: redirect_valid=1, redirect_pc=0x80000100.
4. MRET, mstatus 0x1880, mepc 0x80000044 -> mstatus<=0x1888; redirect to 0x80000044.
5. CSRRW 0xF11 (mvendorid) -> wen=0, rsp_illegal=1, rsp_rdata=0x79737978. Op 7 -> rsp_illegal=1, no write.
6. flush in READ -> no write, no rsp. rst low mid-WRITE -> outputs 0 immediately, IDLE, req_ready=1 after release.
